next_pc_unit: RTL and testbench

//  Next-PC selection stage feeding the PC register's nextPC input; PC loads nextPC every clock.

---
 rtl/next_pc_unit_if.sv | 33 +++
 rtl/next_pc_unit.sv | 123 ++++++++++++
 tb/tb_next_pc_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/next_pc_unit_if.sv
// Control/status bundle between the fetch-decode side (master) and next_pc_unit (slave).
interface next_pc_unit_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      pc;
    logic             stall;
    logic             branch_taken;
    logic [31:0]      branch_offset;
    logic             jump;
    logic [31:0]      jump_target;
    logic             jalr;
    logic [31:0]      jalr_target;
    logic             call;
    logic             ret;
    logic [31:0]      next_pc;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_mismatch;
    logic [CNT_W-1:0] mismatch_count;
    logic             misalign;

    modport master (
        output pc, stall, branch_taken, branch_offset, jump, jump_target,
               jalr, jalr_target, call, ret,
        input  next_pc, ras_empty, ras_full, ras_mismatch, mismatch_count, misalign
    );

    modport slave (
        input  pc, stall, branch_taken, branch_offset, jump, jump_target,
               jalr, jalr_target, call, ret,
        output next_pc, ras_empty, ras_full, ras_mismatch, mismatch_count, misalign
    );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC select with a circular return-address stack used only to flag call/return mismatches.
// Optional feature macro NPC_MISALIGN_TRAP_EN: redirect misaligned targets to TRAP_VECTOR.
module next_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          RAS_DEPTH    = 8,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input logic           clock,
    input logic           reset,
    next_pc_unit_if.slave npc
);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(RAS_DEPTH);

    logic [31:0]      ras_mem_q [RAS_DEPTH];
    ptr_t             top_q, top_d;
    cnt_t             count_q, count_d;
    logic             ras_mismatch_q, ras_mismatch_d;
    logic [CNT_W-1:0] mismatch_count_q, mismatch_count_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      target;
    logic             push, pop, wr_en;
    ptr_t             wr_addr, pop_top;
    cnt_t             pop_count;

    assign pc_plus4 = npc.pc + 32'd4;

    always_comb begin
        if (npc.jalr)              target = npc.jalr_target;
        else if (npc.jump)         target = npc.jump_target;
        else if (npc.branch_taken) target = npc.pc + npc.branch_offset;
        else                       target = pc_plus4;
    end

    assign push = !npc.stall && npc.call && (npc.jump || npc.jalr);
    assign pop  = !npc.stall && npc.ret && npc.jalr;

    // A combined call+ret is modelled literally as pop followed by push.
    always_comb begin
        ras_mismatch_d = 1'b0;
        pop_top        = top_q;
        pop_count      = count_q;
        if (pop) begin
            ras_mismatch_d = (count_q == '0) || (ras_mem_q[top_q] != npc.jalr_target);
            if (count_q != '0) begin
                pop_top   = top_q - 1'b1;
                pop_count = count_q - 1'b1;
            end
        end
        top_d   = pop_top;
        count_d = pop_count;
        wr_addr = pop_top + 1'b1;
        wr_en   = 1'b0;
        if (push) begin
            wr_en   = !reset;
            top_d   = pop_top + 1'b1;
            count_d = (pop_count == FULL_CNT) ? pop_count : pop_count + 1'b1;
        end
        mismatch_count_d = mismatch_count_q;
        if (ras_mismatch_d && (mismatch_count_q != '1)) begin
            mismatch_count_d = mismatch_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            top_q            <= '0;
            count_q          <= '0;
            ras_mismatch_q   <= 1'b0;
            mismatch_count_q <= '0;
        end else begin
            top_q            <= top_d;
            count_q          <= count_d;
            ras_mismatch_q   <= ras_mismatch_d;
            mismatch_count_q <= mismatch_count_d;
        end
    end

    // Stack contents are deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            ras_mem_q[wr_addr] <= pc_plus4;
        end
    end

`ifdef NPC_MISALIGN_TRAP_EN
    logic misaligned_target;
    logic misalign_q, misalign_d;

    assign misaligned_target = (target[1:0] != 2'b00);

    always_comb begin
        misalign_d = misalign_q | (!npc.stall && misaligned_target);
    end

    always_ff @(posedge clock) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end

    assign npc.misalign = misalign_q;
    assign npc.next_pc  = reset             ? RESET_VECTOR :
                          npc.stall         ? npc.pc       :
                          misaligned_target ? TRAP_VECTOR  : target;
`else
    logic unused_trap_vector;

    assign unused_trap_vector = ^TRAP_VECTOR;
    assign npc.misalign       = 1'b0;
    assign npc.next_pc        = reset     ? RESET_VECTOR :
                                npc.stall ? npc.pc       : target;
`endif

    assign npc.ras_empty      = (count_q == '0);
    assign npc.ras_full       = (count_q == FULL_CNT);
    assign npc.ras_mismatch   = ras_mismatch_q;
    assign npc.mismatch_count = mismatch_count_q;
endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: a reference model pushes expectations, outputs pop and compare them.
// Honours NPC_MISALIGN_TRAP_EN the same way the design does.
module tb_next_pc_unit;
    localparam int          DEPTH    = 8;
    localparam int          CW       = 16;
    localparam logic [31:0] RST_VEC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    logic   clock = 1'b0;
    logic   reset = 1'b0;
    exp_t   exp_q[$];
    int     check_count = 0;
    int     pass_count  = 0;

    logic [31:0] m_mem [DEPTH];
    int          m_top     = 0;
    int          m_count   = 0;
    logic        m_mis     = 1'b0;
    logic [CW-1:0] m_mcnt  = '0;
    logic        m_misalign = 1'b0;

    next_pc_unit_if #(.CNT_W(CW)) npc_bus ();

    next_pc_unit #(
        .RESET_VECTOR (RST_VEC),
        .RAS_DEPTH    (DEPTH),
        .CNT_W        (CW),
        .TRAP_VECTOR  (TRAP_VEC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .npc   (npc_bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h, required %h", tag, actual, expected);
    endtask

    function automatic logic [31:0] actual_of(input string tag);
        if (tag == "next_pc")        return npc_bus.next_pc;
        if (tag == "ras_empty")      return {31'b0, npc_bus.ras_empty};
        if (tag == "ras_full")       return {31'b0, npc_bus.ras_full};
        if (tag == "ras_mismatch")   return {31'b0, npc_bus.ras_mismatch};
        if (tag == "mismatch_count") return {16'b0, npc_bus.mismatch_count};
        return {31'b0, npc_bus.misalign};
    endfunction

    function automatic logic [31:0] model_target();
        if (npc_bus.jalr)              return npc_bus.jalr_target;
        if (npc_bus.jump)              return npc_bus.jump_target;
        if (npc_bus.branch_taken)      return npc_bus.pc + npc_bus.branch_offset;
        return npc_bus.pc + 32'd4;
    endfunction

    function automatic logic [31:0] model_next_pc();
        logic [31:0] sel;
        if (reset)         return RST_VEC;
        if (npc_bus.stall) return npc_bus.pc;
        sel = model_target();
`ifdef NPC_MISALIGN_TRAP_EN
        if (sel[1:0] != 2'b00) return TRAP_VEC;
`endif
        return sel;
    endfunction

    task automatic drain_queue();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e.tag, actual_of(e.tag), e.value);
        end
    endtask

    task automatic update_model();
        logic [31:0] sel;
        if (reset) begin
            m_top = 0; m_count = 0; m_mis = 1'b0; m_mcnt = '0; m_misalign = 1'b0;
            return;
        end
        m_mis = 1'b0;
        if (npc_bus.stall) return;
        sel = model_target();
`ifdef NPC_MISALIGN_TRAP_EN
        if (sel[1:0] != 2'b00) m_misalign = 1'b1;
`endif
        if (npc_bus.ret && npc_bus.jalr) begin
            if (m_count == 0 || m_mem[m_top] != npc_bus.jalr_target) m_mis = 1'b1;
            if (m_count != 0) begin
                m_top   = (m_top + DEPTH - 1) % DEPTH;
                m_count = m_count - 1;
            end
        end
        if (npc_bus.call && (npc_bus.jump || npc_bus.jalr)) begin
            m_top        = (m_top + 1) % DEPTH;
            m_mem[m_top] = npc_bus.pc + 32'd4;
            if (m_count < DEPTH) m_count = m_count + 1;
        end
        if (m_mis && m_mcnt != '1) m_mcnt = m_mcnt + 1'b1;
    endtask

    // One clock of stimulus: comb expectation checked before the edge, state expectations after it.
    task automatic applyStimulus(input logic rst, input logic stl, input logic [31:0] pc,
                                 input logic br, input logic [31:0] off,
                                 input logic jmp, input logic [31:0] jtgt,
                                 input logic jr, input logic [31:0] jrtgt,
                                 input logic cl, input logic rt);
        reset                 = rst;
        npc_bus.stall         = stl;
        npc_bus.pc            = pc;
        npc_bus.branch_taken  = br;
        npc_bus.branch_offset = off;
        npc_bus.jump          = jmp;
        npc_bus.jump_target   = jtgt;
        npc_bus.jalr          = jr;
        npc_bus.jalr_target   = jrtgt;
        npc_bus.call          = cl;
        npc_bus.ret           = rt;
        exp_q.push_back('{"next_pc", model_next_pc()});
        #1;
        drain_queue();
        update_model();
        exp_q.push_back('{"ras_empty",      {31'b0, m_count == 0}});
        exp_q.push_back('{"ras_full",       {31'b0, m_count == DEPTH}});
        exp_q.push_back('{"ras_mismatch",   {31'b0, m_mis}});
        exp_q.push_back('{"mismatch_count", {16'b0, m_mcnt}});
        exp_q.push_back('{"misalign",       {31'b0, m_misalign}});
        @(posedge clock);
        #1;
        drain_queue();
    endtask

    task automatic plain(input logic [31:0] pc);
        applyStimulus(0, 0, pc, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] rpc, rtgt;
        int          r;

        // Reset with a full call+jump asserted: nothing must be pushed
        applyStimulus(1, 0, 32'hDEAD_BEEF, 0, 0, 1, 32'h300, 0, 0, 1, 0);
        plain(32'h40);
        applyStimulus(0, 0, 32'h40, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0);
        plain(32'hFFFF_FFFC);
        applyStimulus(0, 1, 32'h40, 0, 0, 1, 32'h200, 0, 0, 1, 0);
        applyStimulus(0, 0, 32'h10, 0, 0, 1, 32'h80, 0, 0, 1, 0);
        applyStimulus(0, 0, 32'h80, 0, 0, 0, 0, 1, 32'h14, 0, 1);
        applyStimulus(0, 0, 32'h14, 0, 0, 0, 0, 1, 32'h50, 0, 1);
        plain(32'h50);

        for (int i = 0; i < 9; i++)
            applyStimulus(0, 0, 32'h1000 + i * 32'h100, 0, 0, 0, 0, 1, 32'h2000 + i * 32'h10, 1, 0);
        for (int i = 8; i >= 0; i--)
            applyStimulus(0, 0, 32'h3000, 0, 0, 0, 0, 1, 32'h1004 + i * 32'h100, 0, 1);

        applyStimulus(0, 0, 32'h300, 0, 0, 1, 32'h400, 0, 0, 1, 0);
        applyStimulus(0, 0, 32'h500, 0, 0, 0, 0, 1, 32'h304, 1, 1);
        applyStimulus(0, 0, 32'h600, 0, 0, 0, 0, 1, 32'h504, 0, 1);
        applyStimulus(0, 0, 32'h700, 0, 0, 0, 0, 1, 32'h998, 1, 1);
        applyStimulus(0, 0, 32'h800, 0, 0, 0, 0, 1, 32'h704, 0, 1);
        applyStimulus(0, 0, 32'h900, 0, 0, 0, 0, 0, 0, 1, 1);

        applyStimulus(0, 0, 32'hA00, 0, 0, 0, 0, 1, 32'h102, 0, 0);
        plain(32'hA10);

        applyStimulus(0, 0, 32'hB00, 0, 0, 1, 32'hC00, 0, 0, 1, 0);
        applyStimulus(1, 0, 32'hC00, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'hC00, 0, 0, 0, 0, 1, 32'hB04, 0, 1);

        for (int i = 0; i < 60; i++) begin
            rpc = $urandom() & 32'hFFFF_FFFC;
            r   = $urandom_range(0, 5);
            case (r)
                0: plain(rpc);
                1: applyStimulus(0, 0, rpc, 1, $urandom() & 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
                2: applyStimulus(0, 0, rpc, 0, 0, 1, $urandom() & 32'hFFFF_FFFC, 0, 0, 1, 0);
                3: applyStimulus(0, 0, rpc, 0, 0, 0, 0, 1, $urandom() & 32'hFFFF_FFFC, 1, 0);
                4: begin
                    rtgt = (m_count > 0 && $urandom_range(0, 3) != 0) ? m_mem[m_top]
                                                                      : ($urandom() & 32'hFFFF_FFFC);
                    applyStimulus(0, 0, rpc, 0, 0, 0, 0, 1, rtgt, $urandom_range(0, 1) == 1, 1);
                end
                default: applyStimulus(0, 1, rpc, 1, 32'h40, 1, 32'h80, 1, 32'hC0, 1, 1);
            endcase
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
